// File: rtl/packet_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// packet_port_arbiter_pkg
//   Shared cache-request packet layout for packet_concat and
//   packet_port_arbiter.
//   Contents:
//     - field widths
//     - LSB-first field offsets
//     - total packet width
//     - a packed struct view of one packet
//   Field order from LSB upwards:
//     addr | data | type | mask | port | valid | is_write | cacheable
// ----------------------------------------------------------------------------
package packet_port_arbiter_pkg;

    localparam int PKT_ADDR_W = 32;
    localparam int PKT_DATA_W = 32;
    localparam int PKT_TYPE_W = 2;
    localparam int PKT_MASK_W = 4;
    localparam int PKT_PORT_W = 4;

    localparam int PKT_ADDR_POS      = 0;
    localparam int PKT_DATA_POS      = PKT_ADDR_POS + PKT_ADDR_W;
    localparam int PKT_TYPE_POS      = PKT_DATA_POS + PKT_DATA_W;
    localparam int PKT_MASK_POS      = PKT_TYPE_POS + PKT_TYPE_W;
    localparam int PKT_PORT_POS      = PKT_MASK_POS + PKT_MASK_W;
    localparam int PKT_VALID_POS     = PKT_PORT_POS + PKT_PORT_W;
    localparam int PKT_IS_WRITE_POS  = PKT_VALID_POS + 1;
    localparam int PKT_CACHEABLE_POS = PKT_IS_WRITE_POS + 1;
    localparam int PKT_WIDTH         = PKT_CACHEABLE_POS + 1;

    // Packed view of one packet; members are listed MSB first.
    typedef struct packed {
        logic                  cacheable;
        logic                  is_write;
        logic                  valid;
        logic [PKT_PORT_W-1:0] port;
        logic [PKT_MASK_W-1:0] mask;
        logic [PKT_TYPE_W-1:0] ptype;
        logic [PKT_DATA_W-1:0] data;
        logic [PKT_ADDR_W-1:0] addr;
    } packet_t;

endpackage

// File: rtl/packet_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// packet_port_arbiter_if
//   Handshake bundle between the per-port requesters and the arbiter.
//   Ports of the bundle:
//     packet_in  : all NUM_PORT request packets
//                  (port i = packet_in[i*PACKET_LEN +: PACKET_LEN])
//     ack_out    : per-port one-cycle capture pulse
//     packet_out : registered winner packet
//     ack_in     : downstream accepted packet_out this cycle
//   Modports:
//     slave  : arbiter side
//     master : requester/cache side
// ----------------------------------------------------------------------------
interface packet_port_arbiter_if
    import packet_port_arbiter_pkg::*;
#(
    parameter int NUM_PORT   = 4,
    parameter int PACKET_LEN = PKT_WIDTH
);
    logic [NUM_PORT*PACKET_LEN-1:0] packet_in;
    logic [NUM_PORT-1:0]            ack_out;
    logic [PACKET_LEN-1:0]          packet_out;
    logic                           ack_in;

    modport slave  (input  packet_in, ack_in, output ack_out, packet_out);
    modport master (output packet_in, ack_in, input  ack_out, packet_out);
endinterface

// File: rtl/packet_port_arbiter_rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin picker.
//   Returns the first set request at or after ptr_i, wrapping modulo NUM_PORT.
//   Ports:
//     req_i   : request vector
//     ptr_i   : search start index
//     grant_o : one-hot grant
//     idx_o   : grant index
//     any_o   : some request present
// ----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_PORT = 4,
    localparam int IDX_W   = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic [NUM_PORT-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [NUM_PORT-1:0] grant_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                any_o
);
    localparam int DW = 2 * NUM_PORT;

    logic [DW-1:0] dbl_req_s;
    logic [DW-1:0] dbl_grant_s;

    // Pick the lowest set bit at or above ptr_i in a doubled request vector.
    // The doubling makes the wrap-around automatic; both halves then fold
    // back into a one-hot NUM_PORT grant.
    always_comb begin
        dbl_req_s   = {req_i, req_i};
        dbl_grant_s = dbl_req_s & ~(dbl_req_s - (DW'(1) << ptr_i));
        grant_o     = dbl_grant_s[NUM_PORT-1:0] | dbl_grant_s[DW-1:NUM_PORT];
        any_o       = |req_i;
    end

    // One-hot to index encoder.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            idx_o = idx_o | (grant_o[i] ? IDX_W'(i) : IDX_W'(0));
        end
    end
endmodule

// File: rtl/packet_port_arbiter.sv
// ----------------------------------------------------------------------------
// packet_port_arbiter
//   Round-robin arbiter between NUM_PORT packet_concat requesters and the
//   unified cache input queue.
//   Per free cycle it does the following:
//     - grants one eligible port
//     - stamps the winner index into the packet port field
//     - holds the winner in a one-entry output register until ack_in
//   Ports:
//     clk_in   : clock
//     reset_in : synchronous active-low reset
//     bus      : slave side of the handshake bundle
//                (packet_in, ack_out, packet_out, ack_in)
// ----------------------------------------------------------------------------
module packet_port_arbiter
    import packet_port_arbiter_pkg::*;
#(
    parameter int NUM_PORT   = 4,
    parameter int PORT_LEN   = PKT_PORT_W,
    parameter int ADDR_LEN   = PKT_ADDR_W,
    parameter int DATA_LEN   = PKT_DATA_W,
    parameter int TYPE_LEN   = PKT_TYPE_W,
    parameter int MASK_LEN   = PKT_MASK_W,
    parameter int PACKET_LEN = PKT_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    packet_port_arbiter_if.slave  bus
);
    localparam int IDX_W     = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam int PORT_POS  = ADDR_LEN + DATA_LEN + TYPE_LEN + MASK_LEN;
    localparam int VALID_POS = PORT_POS + PORT_LEN;

    logic [PACKET_LEN-1:0] packet_out_q, packet_out_d;
    logic [NUM_PORT-1:0]   ack_out_q, ack_out_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [NUM_PORT-1:0]   req_s;
    logic [NUM_PORT-1:0]   elig_s;
    logic [NUM_PORT-1:0]   grant_s;
    logic [IDX_W-1:0]      win_idx_s;
    logic                  any_elig_s;
    logic [PACKET_LEN-1:0] win_pkt_s;
    logic                  out_valid_s;
    logic                  free_s;

    // Request extraction.
    // A port that was acked last cycle may still show its stale packet,
    // so it is masked out for one cycle.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            req_s[i] = bus.packet_in[i*PACKET_LEN + VALID_POS];
        end
        elig_s = req_s & ~ack_out_q;
    end

    rr_priority_picker #(.NUM_PORT(NUM_PORT)) u_picker (
        .req_i   (elig_s),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s),
        .idx_o   (win_idx_s),
        .any_o   (any_elig_s)
    );

    // Winner packet mux, selected by the one-hot grant.
    always_comb begin
        win_pkt_s = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            win_pkt_s = win_pkt_s |
                (grant_s[i] ? bus.packet_in[i*PACKET_LEN +: PACKET_LEN] : {PACKET_LEN{1'b0}});
        end
    end

    // Next-state logic for the output register, ack pulses and rr pointer.
    // The register may drain and refill on the same edge.
    always_comb begin
        out_valid_s  = packet_out_q[VALID_POS];
        free_s       = ~out_valid_s | bus.ack_in;
        packet_out_d = packet_out_q;
        ack_out_d    = '0;
        rr_ptr_d     = rr_ptr_q;
        if (free_s) begin
            if (any_elig_s) begin
                packet_out_d = win_pkt_s;
                packet_out_d[PORT_POS +: PORT_LEN] = PORT_LEN'(win_idx_s);
                ack_out_d = grant_s;
                rr_ptr_d  = (win_idx_s == IDX_W'(NUM_PORT - 1)) ? IDX_W'(0)
                                                                : win_idx_s + IDX_W'(1);
            end else if (out_valid_s) begin
                packet_out_d = '0;
            end else begin
                packet_out_d = packet_out_q;
            end
        end else begin
            packet_out_d = packet_out_q;
        end
    end

    // State registers with synchronous active-low reset; an in-flight packet is dropped.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            packet_out_q <= '0;
            ack_out_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            packet_out_q <= packet_out_d;
            ack_out_q    <= ack_out_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.packet_out = packet_out_q;
    assign bus.ack_out    = ack_out_q;
endmodule

// File: tb/tb_packet_port_arbiter.sv
module tb_packet_port_arbiter;
    import packet_port_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int PL = PKT_WIDTH;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    packet_t exp_q[$];

    packet_port_arbiter_if #(.NUM_PORT(NP), .PACKET_LEN(PL)) bus();

    packet_port_arbiter #(.NUM_PORT(NP)) dut (
        .clk_in   (clk),
        .reset_in (reset_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request packet as a requester would build it.
    // The port field holds a non-index value, so the stamping is visible.
    function automatic packet_t mk_pkt(input int p, input logic [31:0] addr);
        packet_t pk;
        pk.addr      = addr;
        pk.data      = ~addr ^ 32'h5A5A_0000;
        pk.ptype     = 2'(p);
        pk.mask      = 4'(p + 3);
        pk.port      = 4'(12 + p);
        pk.valid     = 1'b1;
        pk.is_write  = 1'(p);
        pk.cacheable = 1'(p >> 1);
        return pk;
    endfunction

    function automatic packet_t stamp(input packet_t pk, input int p);
        packet_t r;
        r      = pk;
        r.port = 4'(p);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input packet_t pk);
        bus.packet_in[p*PL +: PL] = pk;
    endtask

    task automatic do_reset();
        bus.packet_in = '0;
        bus.ack_in    = 1'b0;
        reset_n       = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        packet_t e;
        reset_n    = 1'b0;
        bus.ack_in = 1'b0;
        for (int p = 0; p < NP; p++) set_port(p, mk_pkt(p, 32'h0000_0100 * p));
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus.packet_out !== '0) begin
                failures++;
                $display("FAIL rst_pkt cycle=%0d got=%h exp=0", c, bus.packet_out);
            end
            checks++;
            if (bus.ack_out !== 4'b0000) begin
                failures++;
                $display("FAIL rst_ack cycle=%0d got=%b exp=0000", c, bus.ack_out);
            end
        end
        reset_n    = 1'b1;
        bus.ack_in = 1'b1;
        exp_q.push_back(stamp(mk_pkt(0, 32'h0), 0));
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.ack_out !== 4'b0001) begin
            failures++;
            $display("FAIL rst_first_ack got=%b exp=0001", bus.ack_out);
        end
        checks++;
        if (bus.packet_out !== e) begin
            failures++;
            $display("FAIL rst_first_pkt got=%h exp=%h", bus.packet_out, e);
        end
    endtask

    task automatic test_round_robin();
        int k[NP];
        packet_t e;
        do_reset();
        bus.ack_in = 1'b1;
        for (int p = 0; p < NP; p++) begin
            k[p] = 0;
            set_port(p, mk_pkt(p, 32'h0001_0000 + 32'(p * 256)));
        end
        for (int g = 0; g < 8; g++) begin
            exp_q.push_back(stamp(mk_pkt(g % NP, 32'h0001_0000 + 32'((g % NP) * 256 + g / NP)), g % NP));
        end
        for (int c = 0; c < 8; c++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (bus.ack_out !== (4'b0001 << e.port)) begin
                failures++;
                $display("FAIL rr_ack grant=%0d got=%b exp_port=%0d", c, bus.ack_out, e.port);
            end
            checks++;
            if (bus.packet_out !== e) begin
                failures++;
                $display("FAIL rr_pkt grant=%0d got=%h exp=%h", c, bus.packet_out, e);
            end
            for (int p = 0; p < NP; p++) begin
                if (bus.ack_out[p]) begin
                    k[p]++;
                    set_port(p, mk_pkt(p, 32'h0001_0000 + 32'(p * 256 + k[p])));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rr_sb_left got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        packet_t e, first;
        do_reset();
        bus.ack_in = 1'b0;
        set_port(2, mk_pkt(2, 32'h0000_1000));
        exp_q.push_back(stamp(mk_pkt(2, 32'h0000_1000), 2));
        step();
        first = exp_q.pop_front();
        checks++;
        if (bus.ack_out !== 4'b0100 || bus.packet_out !== first) begin
            failures++;
            $display("FAIL bp_grant ack=%b pkt=%h exp_pkt=%h", bus.ack_out, bus.packet_out, first);
        end
        set_port(2, mk_pkt(2, 32'h0000_2000));
        exp_q.push_back(stamp(mk_pkt(2, 32'h0000_2000), 2));
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (bus.packet_out !== first || bus.ack_out !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d ack=%b pkt=%h exp_pkt=%h", c, bus.ack_out, bus.packet_out, first);
            end
        end
        bus.ack_in = 1'b1;
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.ack_out !== 4'b0100 || bus.packet_out !== e) begin
            failures++;
            $display("FAIL bp_second ack=%b pkt=%h exp_pkt=%h", bus.ack_out, bus.packet_out, e);
        end
        set_port(2, '0);
        step();
        checks++;
        if (bus.packet_out !== '0) begin
            failures++;
            $display("FAIL bp_drain got=%h exp=0", bus.packet_out);
        end
    endtask

    task automatic test_wrap();
        packet_t e;
        do_reset();
        bus.ack_in = 1'b1;
        set_port(3, mk_pkt(3, 32'h0000_3000));
        exp_q.push_back(stamp(mk_pkt(3, 32'h0000_3000), 3));
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.ack_out !== 4'b1000 || bus.packet_out !== e) begin
            failures++;
            $display("FAIL wrap_grant3 ack=%b pkt=%h exp_pkt=%h", bus.ack_out, bus.packet_out, e);
        end
        // Stale packet stays one more cycle; it must not be granted again.
        step();
        checks++;
        if (bus.ack_out !== 4'b0000 || bus.packet_out !== '0) begin
            failures++;
            $display("FAIL wrap_no_regrant ack=%b pkt=%h exp=0", bus.ack_out, bus.packet_out);
        end
        set_port(3, '0);
        step();
        checks++;
        if (bus.ack_out !== 4'b0000) begin
            failures++;
            $display("FAIL wrap_idle got=%b exp=0000", bus.ack_out);
        end
        set_port(0, mk_pkt(0, 32'h0000_4000));
        set_port(3, mk_pkt(3, 32'h0000_5000));
        exp_q.push_back(stamp(mk_pkt(0, 32'h0000_4000), 0));
        exp_q.push_back(stamp(mk_pkt(3, 32'h0000_5000), 3));
        for (int c = 0; c < 2; c++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (bus.ack_out !== (4'b0001 << e.port) || bus.packet_out !== e) begin
                failures++;
                $display("FAIL wrap_order idx=%0d ack=%b pkt=%h exp_pkt=%h", c, bus.ack_out, bus.packet_out, e);
            end
            for (int p = 0; p < NP; p++) if (bus.ack_out[p]) set_port(p, '0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_sb_left got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        packet_t e;
        do_reset();
        bus.ack_in = 1'b0;
        set_port(0, mk_pkt(0, 32'h0000_6000));
        exp_q.push_back(stamp(mk_pkt(0, 32'h0000_6000), 0));
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.ack_out !== 4'b0001 || bus.packet_out !== e) begin
            failures++;
            $display("FAIL b2b_first ack=%b pkt=%h exp_pkt=%h", bus.ack_out, bus.packet_out, e);
        end
        set_port(0, '0);
        set_port(1, mk_pkt(1, 32'h0000_7000));
        exp_q.push_back(stamp(mk_pkt(1, 32'h0000_7000), 1));
        bus.ack_in = 1'b1;
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.ack_out !== 4'b0010 || bus.packet_out !== e) begin
            failures++;
            $display("FAIL b2b_refill ack=%b pkt=%h exp_pkt=%h", bus.ack_out, bus.packet_out, e);
        end
        set_port(1, '0);
        step();
        checks++;
        if (bus.packet_out !== '0 || bus.ack_out !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_drain ack=%b pkt=%h exp=0", bus.ack_out, bus.packet_out);
        end
    endtask

    task automatic test_mid_reset();
        packet_t e;
        do_reset();
        bus.ack_in = 1'b0;
        set_port(2, mk_pkt(2, 32'h0000_8000));
        exp_q.push_back(stamp(mk_pkt(2, 32'h0000_8000), 2));
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.ack_out !== 4'b0100 || bus.packet_out !== e) begin
            failures++;
            $display("FAIL mrst_grant ack=%b pkt=%h exp_pkt=%h", bus.ack_out, bus.packet_out, e);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (bus.packet_out !== '0 || bus.ack_out !== 4'b0000) begin
            failures++;
            $display("FAIL mrst_clear ack=%b pkt=%h exp=0", bus.ack_out, bus.packet_out);
        end
        reset_n    = 1'b1;
        bus.ack_in = 1'b1;
        set_port(2, '0);
        set_port(1, mk_pkt(1, 32'h0000_9000));
        set_port(3, mk_pkt(3, 32'h0000_A000));
        exp_q.push_back(stamp(mk_pkt(1, 32'h0000_9000), 1));
        exp_q.push_back(stamp(mk_pkt(3, 32'h0000_A000), 3));
        for (int c = 0; c < 2; c++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (bus.ack_out !== (4'b0001 << e.port) || bus.packet_out !== e) begin
                failures++;
                $display("FAIL mrst_ptr idx=%0d ack=%b pkt=%h exp_pkt=%h", c, bus.ack_out, bus.packet_out, e);
            end
            for (int p = 0; p < NP; p++) if (bus.ack_out[p]) set_port(p, '0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mrst_sb_left got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        bus.ack_in    = 1'b0;
        bus.packet_in = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
